// File: rtl/sysram_stream_packer.sv
// sysram_stream_packer
//   Reads a contiguous window of system RAM and packs PACK consecutive RAM
//   words into each AXI-Stream beat. The final beat of a transfer may be
//   partial: it carries tlast and a tkeep that covers only the filled lanes.
//   Unfilled lanes of that beat read as zero.
//   Reads are issued only while a packed-beat slot is guaranteed downstream,
//   so a stalled stream never causes a RAM return to be dropped.
//
// Ports
//   sysRAM_clk, rstn       clock, asynchronous active-low reset
//   start, abort           one-cycle transfer request / synchronous flush
//   start_addr, len_words  first RAM word address, transfer length in words
//   busy, done, err_len    status: in transfer, completion pulse, zero-length pulse
//   ram_rd_en, ram_addr    RAM read strobe and address (registered)
//   ram_rdata              RAM data, valid RD_LAT cycles after the strobe
//   m_tdata .. m_tready    AXI-Stream master; word k at bits [k*RAM_DW +: RAM_DW]
module sysram_stream_packer #(
  parameter int RAM_DW     = 32,
  parameter int PACK       = 2,
  parameter int AW         = 16,
  parameter int LEN_W      = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       sysRAM_clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [AW-1:0]              start_addr,
  input  logic [LEN_W-1:0]           len_words,
  output logic                       busy,
  output logic                       done,
  output logic                       err_len,
  output logic                       ram_rd_en,
  output logic [AW-1:0]              ram_addr,
  input  logic [RAM_DW-1:0]          ram_rdata,
  output logic [RAM_DW*PACK-1:0]     m_tdata,
  output logic [RAM_DW*PACK/8-1:0]   m_tkeep,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  input  logic                       m_tready
);

  localparam int BEAT_W  = RAM_DW * PACK;
  localparam int KEEP_W  = BEAT_W / 8;
  localparam int BPW     = RAM_DW / 8;
  localparam int LANE_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 2;
  localparam int ENTRY_W = 1 + KEEP_W + BEAT_W;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                err_len_reg;
  logic                rd_en_reg;
  logic [AW-1:0]       ram_addr_reg;
  logic [AW-1:0]       addr_cnt_reg;
  logic [LEN_W-1:0]    issue_left_reg;
  logic [LEN_W-1:0]    ret_left_reg;
  logic [LANE_W-1:0]   issue_lane_reg;
  logic [LANE_W-1:0]   pack_lane_reg;
  logic [BEAT_W-1:0]   pack_data_reg;
  logic [RD_LAT-1:0]   vld_sr_reg;
  logic [CNT_W-1:0]    reserved_reg;
  logic [CNT_W-1:0]    fifo_cnt_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;

  logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic                ret_vld;
  logic                ret_final;
  logic                push;
  logic                pop;
  logic                new_beat;
  logic                credit_ok;
  logic                issue;
  logic [RD_LAT:0]     vld_ext;
  logic [BEAT_W-1:0]   beat_data;
  logic [KEEP_W-1:0]   beat_keep;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;
  logic                head_last;

  // ---------------------------------------------------------------------------
  // Issue side
  // ---------------------------------------------------------------------------
  // reserved_reg counts beats that have had their first read issued but have
  // not yet been pushed into the FIFO (this includes the beat being packed).
  // Only the first word of a beat needs a fresh slot; the remaining words of
  // that beat already own one, so they may always issue.
  assign new_beat  = (issue_lane_reg == '0);
  assign credit_ok = !new_beat || ((fifo_cnt_reg + reserved_reg) < DEPTH_C);
  assign issue     = (state_reg == ISSUE) && credit_ok;

  // ---------------------------------------------------------------------------
  // Return side
  // ---------------------------------------------------------------------------
  // The valid shift register is fed by the registered strobe, so its last tap
  // lines up with ram_rdata exactly RD_LAT cycles after ram_rd_en.
  assign vld_ext   = {vld_sr_reg, rd_en_reg};
  assign ret_vld   = vld_sr_reg[RD_LAT-1];
  assign ret_final = (ret_left_reg == LEN_W'(1));
  assign push      = ret_vld && ((pack_lane_reg == LAST_LANE) || ret_final);

  // The packer register is cleared after every push, so lanes above the
  // current one are still zero when a short final beat is pushed.
  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      assign beat_data[gi*RAM_DW +: RAM_DW] =
        (pack_lane_reg == LANE_W'(gi)) ? ram_rdata : pack_data_reg[gi*RAM_DW +: RAM_DW];
      assign beat_keep[gi*BPW +: BPW] =
        (LANE_W'(gi) <= pack_lane_reg) ? {BPW{1'b1}} : {BPW{1'b0}};
    end
  endgenerate

  assign push_entry = {ret_final, beat_keep, beat_data};

  // ---------------------------------------------------------------------------
  // Output FIFO head
  // ---------------------------------------------------------------------------
  // The head entry can only be rewritten once it has been popped, because the
  // issue credit never lets a push land on an occupied slot.
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign head_last  = head_entry[ENTRY_W-1];
  assign m_tvalid   = (fifo_cnt_reg != '0);
  assign pop        = m_tvalid && m_tready;
  assign m_tdata    = m_tvalid ? head_entry[BEAT_W-1:0] : '0;
  assign m_tkeep    = m_tvalid ? head_entry[BEAT_W +: KEEP_W] : '0;
  assign m_tlast    = m_tvalid && head_last;

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err_len   = err_len_reg;
  assign ram_rd_en = rd_en_reg;
  assign ram_addr  = ram_addr_reg;

  always_ff @(posedge sysRAM_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Control, counters and FIFO pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysRAM_clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_len_reg    <= 1'b0;
      rd_en_reg      <= 1'b0;
      ram_addr_reg   <= '0;
      addr_cnt_reg   <= '0;
      issue_left_reg <= '0;
      ret_left_reg   <= '0;
      issue_lane_reg <= '0;
      pack_lane_reg  <= '0;
      pack_data_reg  <= '0;
      vld_sr_reg     <= '0;
      reserved_reg   <= '0;
      fifo_cnt_reg   <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else if (abort) begin
      // Flush everything; clearing the valid shift register discards any
      // RAM returns still in flight.
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_len_reg    <= 1'b0;
      rd_en_reg      <= 1'b0;
      issue_left_reg <= '0;
      ret_left_reg   <= '0;
      issue_lane_reg <= '0;
      pack_lane_reg  <= '0;
      pack_data_reg  <= '0;
      vld_sr_reg     <= '0;
      reserved_reg   <= '0;
      fifo_cnt_reg   <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      done_reg    <= 1'b0;
      err_len_reg <= 1'b0;
      rd_en_reg   <= issue;
      vld_sr_reg  <= vld_ext[RD_LAT-1:0];

      if (issue) begin
        ram_addr_reg   <= addr_cnt_reg;
        addr_cnt_reg   <= addr_cnt_reg + AW'(1);
        issue_left_reg <= issue_left_reg - LEN_W'(1);
        issue_lane_reg <= (issue_lane_reg == LAST_LANE) ? '0 : issue_lane_reg + LANE_W'(1);
      end

      if (ret_vld) begin
        ret_left_reg  <= ret_left_reg - LEN_W'(1);
        pack_lane_reg <= push ? '0 : pack_lane_reg + LANE_W'(1);
        pack_data_reg <= push ? '0 : beat_data;
      end

      case ({issue && new_beat, push})
        2'b10:   reserved_reg <= reserved_reg + CNT_W'(1);
        2'b01:   reserved_reg <= reserved_reg - CNT_W'(1);
        default: reserved_reg <= reserved_reg;
      endcase

      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            if (len_words == '0) begin
              err_len_reg <= 1'b1;
            end else begin
              addr_cnt_reg   <= start_addr;
              issue_left_reg <= len_words;
              ret_left_reg   <= len_words;
              issue_lane_reg <= '0;
              pack_lane_reg  <= '0;
              busy_reg       <= 1'b1;
              state_reg      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue && (issue_left_reg == LEN_W'(1))) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysram_stream_packer.sv
// Directed testbench for sysram_stream_packer (RAM_DW=32, PACK=2, AW=16,
// LEN_W=16, RD_LAT=2, FIFO_DEPTH=8). The RAM model returns its own address
// (zero-extended) two cycles after each strobe.
module tb_sysram_stream_packer;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        abort;
  logic [15:0] start_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic        err_len;
  logic        ram_rd_en;
  logic [15:0] ram_addr;
  logic [31:0] ram_rdata;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [63:0] beat_data_q[$];
  logic [7:0]  beat_keep_q[$];
  logic        beat_last_q[$];
  logic [15:0] addr_q[$];
  int done_cnt = 0;
  int err_cnt = 0;
  int tlast_cyc = 0;
  int done_cyc = 0;

  logic [15:0] ram_pipe0;
  logic [15:0] ram_pipe1;

  sysram_stream_packer #(
    .RAM_DW(32), .PACK(2), .AW(16), .LEN_W(16), .RD_LAT(2), .FIFO_DEPTH(8)
  ) dut (
    .sysRAM_clk (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .len_words  (len_words),
    .busy       (busy),
    .done       (done),
    .err_len    (err_len),
    .ram_rd_en  (ram_rd_en),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data = address, two-cycle read latency.
  always @(posedge clk) begin
    ram_pipe0 <= ram_addr;
    ram_pipe1 <= ram_pipe0;
  end
  assign ram_rdata = {16'h0000, ram_pipe1};

  // Monitor: one line per accepted beat.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_tvalid && m_tready) begin
        beat_data_q.push_back(m_tdata);
        beat_keep_q.push_back(m_tkeep);
        beat_last_q.push_back(m_tlast);
        if (m_tlast) tlast_cyc <= cyc;
        $display("beat #%0d data=%h keep=%h last=%b", beat_data_q.size(), m_tdata, m_tkeep, m_tlast);
      end
      if (ram_rd_en) addr_q.push_back(ram_addr);
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (err_len) err_cnt <= err_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] addr, input logic [15:0] len);
    @(posedge clk); #1;
    start = 1'b1; start_addr = addr; len_words = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int bb;
    int ab;
    int dc;
    int ec;
    int stall_bad;
    int order_bad;
    logic [63:0] e;

    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = '0; len_words = '0; m_tready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",   64'(busy), 64'd0);
    check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("rst_rd_en",  64'(ram_rd_en), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_eq("idle_done",  64'(done), 64'd0);

    // ---- 8 words from 0x0010, full ready ----
    bb = beat_data_q.size(); dc = done_cnt;
    pulse_start(16'h0010, 16'd8);
    @(negedge clk);
    check_eq("t1_busy", 64'(busy), 64'd1);
    wait_done(100);
    settle();
    check_eq("t1_beats", 64'(beat_data_q.size() - bb), 64'd4);
    check_eq("t1_beat0", beat_data_q[bb], 64'h00000011_00000010);
    check_eq("t1_beat3", beat_data_q[bb+3], 64'h00000017_00000016);
    check_eq("t1_last", {60'd0, beat_last_q[bb+3], beat_last_q[bb+2], beat_last_q[bb+1], beat_last_q[bb]}, 64'h8);
    check_eq("t1_keep", {32'd0, beat_keep_q[bb+3], beat_keep_q[bb+2], beat_keep_q[bb+1], beat_keep_q[bb]}, 64'hFFFFFFFF);
    check_eq("t1_done_lat", 64'(done_cyc - tlast_cyc), 64'd1);
    check_eq("t1_done_cnt", 64'(done_cnt - dc), 64'd1);
    check_eq("t1_busy_end", 64'(busy), 64'd0);

    // ---- 5 words: partial final beat ----
    bb = beat_data_q.size();
    pulse_start(16'h0020, 16'd5);
    wait_done(100);
    settle();
    check_eq("t2_beats", 64'(beat_data_q.size() - bb), 64'd3);
    check_eq("t2_last_data", beat_data_q[bb+2], 64'h00000000_00000024);
    check_eq("t2_last_keep", 64'(beat_keep_q[bb+2]), 64'h0F);
    check_eq("t2_last_flag", 64'(beat_last_q[bb+2]), 64'd1);
    check_eq("t2_mid_last", 64'(beat_last_q[bb+1]), 64'd0);

    // ---- 64 words with the stream stalled ----
    bb = beat_data_q.size(); ab = addr_q.size();
    m_tready = 1'b0;
    pulse_start(16'h0100, 16'd64);
    stall_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_tvalid && (m_tdata !== 64'h00000101_00000100)) stall_bad++;
    end
    #1;
    check_eq("t3_stall_reads", 64'(addr_q.size() - ab), 64'd16);
    check_eq("t3_tvalid", 64'(m_tvalid), 64'd1);
    check_eq("t3_hold", 64'(stall_bad), 64'd0);
    check_eq("t3_no_beats", 64'(beat_data_q.size() - bb), 64'd0);
    @(posedge clk); #1;
    m_tready = 1'b1;
    wait_done(400);
    settle();
    check_eq("t3_beats", 64'(beat_data_q.size() - bb), 64'd32);
    check_eq("t3_reads", 64'(addr_q.size() - ab), 64'd64);
    order_bad = 0;
    for (int i = 0; i < 32; i++) begin
      e = {32'h101 + 32'(2*i), 32'h100 + 32'(2*i)};
      if ((bb + i >= beat_data_q.size()) || (beat_data_q[bb+i] !== e)) order_bad++;
    end
    check_eq("t3_order", 64'(order_bad), 64'd0);

    // ---- address wrap ----
    bb = beat_data_q.size(); ab = addr_q.size();
    pulse_start(16'hFFFE, 16'd4);
    wait_done(100);
    settle();
    check_eq("t4_nreads", 64'(addr_q.size() - ab), 64'd4);
    check_eq("t4_addr0", 64'(addr_q[ab]),   64'hFFFE);
    check_eq("t4_addr1", 64'(addr_q[ab+1]), 64'hFFFF);
    check_eq("t4_addr2", 64'(addr_q[ab+2]), 64'h0000);
    check_eq("t4_addr3", 64'(addr_q[ab+3]), 64'h0001);
    check_eq("t4_beat1", beat_data_q[bb+1], 64'h00000001_00000000);

    // ---- zero length, then start while busy ----
    ab = addr_q.size(); ec = err_cnt;
    pulse_start(16'h0040, 16'd0);
    @(negedge clk);
    check_eq("t5_busy0", 64'(busy), 64'd0);
    settle();
    check_eq("t5_err", 64'(err_cnt - ec), 64'd1);
    check_eq("t5_noreads", 64'(addr_q.size() - ab), 64'd0);
    bb = beat_data_q.size();
    pulse_start(16'h0040, 16'd16);
    repeat (3) @(posedge clk);
    pulse_start(16'h0200, 16'd4);
    wait_done(200);
    settle();
    check_eq("t5_beats", 64'(beat_data_q.size() - bb), 64'd8);
    check_eq("t5_reads", 64'(addr_q.size() - ab), 64'd16);
    check_eq("t5_first", 64'(addr_q[ab]), 64'h0040);

    // ---- abort together with start in IDLE ----
    ab = addr_q.size();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; start_addr = 16'h0500; len_words = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("t6_sa_busy", 64'(busy), 64'd0);
    settle();
    check_eq("t6_sa_reads", 64'(addr_q.size() - ab), 64'd0);

    // ---- abort after 3 beats of a 16-word transfer ----
    bb = beat_data_q.size(); dc = done_cnt;
    pulse_start(16'h0080, 16'd16);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (beat_data_q.size() - bb >= 3) break;
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("t6_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_rd_en", 64'(ram_rd_en), 64'd0);
    #1;
    ab = beat_data_q.size();
    repeat (10) @(negedge clk);
    #1;
    check_eq("t6_no_more", 64'(beat_data_q.size() - ab), 64'd0);
    check_eq("t6_no_done", 64'(done_cnt - dc), 64'd0);
    bb = beat_data_q.size();
    pulse_start(16'h0300, 16'd2);
    wait_done(100);
    settle();
    check_eq("t6_beats", 64'(beat_data_q.size() - bb), 64'd1);
    check_eq("t6_data", beat_data_q[bb], 64'h00000301_00000300);
    check_eq("t6_last", 64'(beat_last_q[bb]), 64'd1);
    check_eq("t6_keep", 64'(beat_keep_q[bb]), 64'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
